// File: rtl/rx_watchdog_mc_pkg.sv
`default_nettype none
// rx_watchdog_mc_pkg: FSM states, fault-cause bit positions and the saturating abs helper
// shared by the receiver watchdog. Rev 1.0
package rx_watchdog_mc_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMED     = 2'd1,
        S_RST_PULSE = 2'd2,
        S_HOLDOFF   = 2'd3
    } wd_state_t;

    localparam int CAUSE_DC  = 0;
    localparam int CAUSE_LEN = 1;
    localparam int CAUSE_EQ  = 2;

    // -2^15 has no positive counterpart; clamp it so it never reads as small
    function automatic logic [15:0] abs_sat16(input logic signed [15:0] v);
        if (v == 16'sh8000) begin
            return 16'h7FFF;
        end else if (v < 16'sd0) begin
            return 16'(-v);
        end else begin
            return 16'(v);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_watchdog_mc_dc_sign_monitor.sv
`default_nettype none
// rx_watchdog_mc_dc_sign_monitor: one channel's sliding window of I/Q sign bits with non-negative
// counts; flags a DC-stuck channel once the window has filled. Rev 1.0
module rx_watchdog_mc_dc_sign_monitor
    import rx_watchdog_mc_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int DC_WIN_LOG2   = 5
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    input  logic                       sample,
    input  logic [2*IQ_DATA_WIDTH-1:0] iq,
    input  logic [7:0]                 dc_th,
    output logic                       dc_fault
);

    localparam int W  = 1 << DC_WIN_LOG2;
    localparam int CW = DC_WIN_LOG2 + 1;
    localparam int TW = ((CW > 8) ? CW : 8) + 1;

    logic [W-1:0]  sh_i, sh_q;
    logic [CW-1:0] cnt_i, cnt_q, fill;
    logic          nn_i, nn_q, full, th_on;
    logic [TW-1:0] th_w, hi_w, ci_w, cq_w;
    logic          unused_mag;

    assign nn_i = ~iq[2*IQ_DATA_WIDTH-1];
    assign nn_q = ~iq[IQ_DATA_WIDTH-1];
    assign unused_mag = ^{iq[2*IQ_DATA_WIDTH-2:IQ_DATA_WIDTH], iq[IQ_DATA_WIDTH-2:0]};

    // Shift regs start at zero, so the bit leaving is 0 until the window is full
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_i  <= '0;
            sh_q  <= '0;
            cnt_i <= '0;
            cnt_q <= '0;
            fill  <= '0;
        end else if (clr) begin
            sh_i  <= '0;
            sh_q  <= '0;
            cnt_i <= '0;
            cnt_q <= '0;
            fill  <= '0;
        end else if (sample) begin
            sh_i  <= {sh_i[W-2:0], nn_i};
            sh_q  <= {sh_q[W-2:0], nn_q};
            cnt_i <= cnt_i + CW'(nn_i) - CW'(sh_i[W-1]);
            cnt_q <= cnt_q + CW'(nn_q) - CW'(sh_q[W-1]);
            if (fill != CW'(W)) begin
                fill <= fill + CW'(1);
            end
        end
    end

    assign full  = (fill == CW'(W));
    assign th_w  = TW'(dc_th);
    assign hi_w  = TW'(W) - th_w;
    assign ci_w  = TW'(cnt_i);
    assign cq_w  = TW'(cnt_q);
    assign th_on = (dc_th != 8'd0) && (th_w < TW'(W / 2));

    assign dc_fault = full && th_on &&
                      ((ci_w < th_w) || (ci_w > hi_w) || (cq_w < th_w) || (cq_w > hi_w));

endmodule
`default_nettype wire

// File: rtl/rx_watchdog_mc.sv
`default_nettype none
// rx_watchdog_mc: multi-channel RX watchdog (DC-stuck IQ, SIGNAL length window, collapsed equalizer)
// that issues a fixed-width receiver reset then a holdoff, and keeps fault statistics. Rev 1.0
module rx_watchdog_mc
    import rx_watchdog_mc_pkg::*;
#(
    parameter int IQ_DATA_WIDTH    = 16,
    parameter int NUM_CH           = 2,
    parameter int LEN_WIDTH        = 16,
    parameter int DC_WIN_LOG2      = 5,
    parameter int EQ_CNT_WIDTH     = 6,
    parameter int EQ_SMALL_MAG     = 4,
    parameter int RST_PULSE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES   = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              enable,
    input  logic                              power_trigger,
    input  logic [NUM_CH-1:0]                 ch_enable,
    input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] iq_in,
    input  logic                              iq_valid,
    input  logic                              sig_valid,
    input  logic [LEN_WIDTH-1:0]              signal_len,
    input  logic [LEN_WIDTH-1:0]              min_len_th,
    input  logic [LEN_WIDTH-1:0]              max_len_th,
    input  logic [7:0]                        dc_th,
    input  logic                              eq_monitor_enable,
    input  logic [EQ_CNT_WIDTH-1:0]           small_eq_th,
    input  logic [31:0]                       equalizer,
    input  logic                              equalizer_valid,
    input  logic                              stat_clear,
    output logic                              receiver_rst,
    output logic [2:0]                        rst_cause,
    output logic [15:0]                       rst_count,
    output logic [1:0]                        wd_state
);

    localparam int TMAX  = (RST_PULSE_CYCLES > HOLDOFF_CYCLES) ? RST_PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);

    wd_state_t               state, state_nx;
    logic                    armed, go;
    logic [NUM_CH-1:0]       dc_flt;
    logic                    dc_fault, len_fault, eq_fault, eq_small, fault_evt;
    logic [2:0]              cause_vec;
    logic [EQ_CNT_WIDTH-1:0] eq_cnt;
    logic [TMR_W-1:0]        tmr;

    assign armed = (state == S_ARMED);
    assign go    = enable & power_trigger;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_dc
        rx_watchdog_mc_dc_sign_monitor #(
            .IQ_DATA_WIDTH (IQ_DATA_WIDTH),
            .DC_WIN_LOG2   (DC_WIN_LOG2)
        ) u_mon (
            .clk      (clk),
            .rstn     (rstn),
            .clr      (!armed),
            .sample   (armed & iq_valid),
            .iq       (iq_in[k*2*IQ_DATA_WIDTH +: 2*IQ_DATA_WIDTH]),
            .dc_th    (dc_th),
            .dc_fault (dc_flt[k])
        );
    end

    assign dc_fault  = |(dc_flt & ch_enable);
    assign len_fault = sig_valid &&
                       (((min_len_th != '0) && (signal_len < min_len_th)) ||
                        ((max_len_th != '0) && (signal_len > max_len_th)));

    assign eq_small = (abs_sat16(equalizer[31:16]) < 16'(EQ_SMALL_MAG)) &&
                      (abs_sat16(equalizer[15:0])  < 16'(EQ_SMALL_MAG));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eq_cnt <= '0;
        end else if (!armed) begin
            eq_cnt <= '0;
        end else if (equalizer_valid && eq_monitor_enable) begin
            if (!eq_small) begin
                eq_cnt <= '0;
            end else if (eq_cnt != '1) begin
                eq_cnt <= eq_cnt + EQ_CNT_WIDTH'(1);
            end
        end
    end

    assign eq_fault = eq_monitor_enable && (small_eq_th != '0) && (eq_cnt >= small_eq_th);

    always_comb begin
        cause_vec            = 3'b000;
        cause_vec[CAUSE_DC]  = dc_fault;
        cause_vec[CAUSE_LEN] = len_fault;
        cause_vec[CAUSE_EQ]  = eq_fault;
    end

    assign fault_evt = armed && (cause_vec != 3'b000);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:      if (go) state_nx = S_ARMED;
            S_ARMED: begin
                if (fault_evt) state_nx = S_RST_PULSE;
                else if (!go)  state_nx = S_IDLE;
            end
            S_RST_PULSE: if (tmr == TMR_W'(RST_PULSE_CYCLES - 1)) state_nx = S_HOLDOFF;
            S_HOLDOFF:   if (tmr == TMR_W'(HOLDOFF_CYCLES - 1))   state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // tmr counts cycles spent in the current pulse/holdoff phase
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            tmr          <= '0;
            receiver_rst <= 1'b0;
        end else begin
            state        <= state_nx;
            receiver_rst <= (state_nx == S_RST_PULSE);
            if (state_nx != state) begin
                tmr <= '0;
            end else if ((state == S_RST_PULSE) || (state == S_HOLDOFF)) begin
                tmr <= tmr + TMR_W'(1);
            end else begin
                tmr <= '0;
            end
        end
    end

    // A clear in the same cycle as a fault wins for the statistics
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_cause <= 3'b000;
            rst_count <= 16'h0000;
        end else if (stat_clear) begin
            rst_cause <= 3'b000;
            rst_count <= 16'h0000;
        end else if (fault_evt) begin
            rst_cause <= cause_vec;
            if (rst_count != 16'hFFFF) begin
                rst_count <= rst_count + 16'h0001;
            end
        end
    end

    assign wd_state = state;

endmodule
`default_nettype wire

// File: tb/tb_rx_watchdog_mc.sv
`default_nettype none
// tb_rx_watchdog_mc: directed scenarios plus randomized traffic, compared every cycle against a
// queue-based behavioural model of the watchdog. Rev 1.0
module tb_rx_watchdog_mc;

    localparam int IQW  = 16;
    localparam int NCH  = 2;
    localparam int LW   = 16;
    localparam int WL   = 5;
    localparam int ECW  = 6;
    localparam int SMAG = 4;
    localparam int RPC  = 4;
    localparam int HOC  = 32;
    localparam int W    = 1 << WL;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  enable = 1'b0;
    logic                  power_trigger = 1'b1;
    logic [NCH-1:0]        ch_enable = '0;
    logic [NCH*2*IQW-1:0]  iq_in = '0;
    logic                  iq_valid = 1'b0;
    logic                  sig_valid = 1'b0;
    logic [LW-1:0]         signal_len = '0;
    logic [LW-1:0]         min_len_th = '0;
    logic [LW-1:0]         max_len_th = '0;
    logic [7:0]            dc_th = '0;
    logic                  eq_monitor_enable = 1'b0;
    logic [ECW-1:0]        small_eq_th = '0;
    logic [31:0]           equalizer = '0;
    logic                  equalizer_valid = 1'b0;
    logic                  stat_clear = 1'b0;
    logic                  receiver_rst;
    logic [2:0]            rst_cause;
    logic [15:0]           rst_count;
    logic [1:0]            wd_state;

    rx_watchdog_mc #(
        .IQ_DATA_WIDTH    (IQW),
        .NUM_CH           (NCH),
        .LEN_WIDTH        (LW),
        .DC_WIN_LOG2      (WL),
        .EQ_CNT_WIDTH     (ECW),
        .EQ_SMALL_MAG     (SMAG),
        .RST_PULSE_CYCLES (RPC),
        .HOLDOFF_CYCLES   (HOC)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .enable            (enable),
        .power_trigger     (power_trigger),
        .ch_enable         (ch_enable),
        .iq_in             (iq_in),
        .iq_valid          (iq_valid),
        .sig_valid         (sig_valid),
        .signal_len        (signal_len),
        .min_len_th        (min_len_th),
        .max_len_th        (max_len_th),
        .dc_th             (dc_th),
        .eq_monitor_enable (eq_monitor_enable),
        .small_eq_th       (small_eq_th),
        .equalizer         (equalizer),
        .equalizer_valid   (equalizer_valid),
        .stat_clear        (stat_clear),
        .receiver_rst      (receiver_rst),
        .rst_cause         (rst_cause),
        .rst_count         (rst_count),
        .wd_state          (wd_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state = 0;     // 0 idle, 1 armed, 2 reset pulse, 3 holdoff
    int m_left  = 0;     // cycles left in pulse/holdoff
    int m_cause = 0;
    int m_count = 0;
    int m_eq_run = 0;
    bit qi[NCH][$];      // per-channel window of "I non-negative" flags, oldest first
    bit qq[NCH][$];

    function automatic bit is_small(input logic [15:0] v);
        int s;
        int a;
        s = int'($signed(v));
        a = (s < 0) ? -s : s;
        if (a > 32767) a = 32767;
        return a < SMAG;
    endfunction

    task model_clear_detectors();
        for (int c = 0; c < NCH; c++) begin
            qi[c].delete();
            qq[c].delete();
        end
        m_eq_run = 0;
    endtask

    task model_reset();
        m_state = 0;
        m_left  = 0;
        m_cause = 0;
        m_count = 0;
        model_clear_detectors();
    endtask

    task model_step();
        bit armed_now;
        bit dcf;
        bit lf;
        bit ef;
        bit fault;
        int cv;
        int ci;
        int cq;
        bit go;
        armed_now = (m_state == 1);
        go = enable && power_trigger;
        dcf = 0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_enable[c] && dc_th != 0 && int'(dc_th) < W / 2 && qi[c].size() == W) begin
                ci = 0;
                cq = 0;
                for (int j = 0; j < W; j++) begin
                    ci += int'(qi[c][j]);
                    cq += int'(qq[c][j]);
                end
                if (ci < int'(dc_th) || ci > W - int'(dc_th) ||
                    cq < int'(dc_th) || cq > W - int'(dc_th)) dcf = 1;
            end
        end
        lf = sig_valid && ((min_len_th != 0 && signal_len < min_len_th) ||
                           (max_len_th != 0 && signal_len > max_len_th));
        ef = eq_monitor_enable && small_eq_th != 0 && m_eq_run >= int'(small_eq_th);
        cv = (ef ? 4 : 0) + (lf ? 2 : 0) + (dcf ? 1 : 0);
        fault = armed_now && cv != 0;

        if (stat_clear) begin
            m_cause = 0;
            m_count = 0;
        end else if (fault) begin
            m_cause = cv;
            m_count = (m_count < 65535) ? m_count + 1 : 65535;
        end

        if (armed_now) begin
            if (iq_valid) begin
                for (int c = 0; c < NCH; c++) begin
                    qi[c].push_back(!iq_in[c*2*IQW + 2*IQW - 1]);
                    qq[c].push_back(!iq_in[c*2*IQW + IQW - 1]);
                    if (qi[c].size() > W) void'(qi[c].pop_front());
                    if (qq[c].size() > W) void'(qq[c].pop_front());
                end
            end
            if (equalizer_valid && eq_monitor_enable) begin
                if (is_small(equalizer[31:16]) && is_small(equalizer[15:0]))
                    m_eq_run = (m_eq_run < (1 << ECW) - 1) ? m_eq_run + 1 : m_eq_run;
                else
                    m_eq_run = 0;
            end
        end else begin
            model_clear_detectors();
        end

        case (m_state)
            0: if (go) m_state = 1;
            1: begin
                if (fault) begin
                    m_state = 2;
                    m_left  = RPC;
                end else if (!go) begin
                    m_state = 0;
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) begin
                    m_state = 3;
                    m_left  = HOC;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_state = 0;
            end
        endcase
    endtask

    // Compare process: model advances on each edge, outputs checked 1 time unit later
    always @(posedge clk) begin
        if (!rstn) model_reset();
        else       model_step();
        #1;
        check("cyc_receiver_rst", 32'(receiver_rst), 32'(m_state == 2));
        check("cyc_wd_state",     32'(wd_state),     32'(m_state));
        check("cyc_rst_cause",    32'(rst_cause),    32'(m_cause));
        check("cyc_rst_count",    32'(rst_count),    32'(m_count));
    end

    // ---------------- stimulus ----------------
    int  iq_mode = 0;   // 0 hold, 1 ch0 stuck, 2 ch1 stuck, 3 random
    bit  alt = 0;
    bit  stuck[NCH];

    task automatic drive_iq();
        case (iq_mode)
            1: begin
                iq_in[31:16] = 16'sd100;
                iq_in[15:0]  = alt ? 16'sd50 : -16'sd50;
                iq_in[63:48] = alt ? 16'sd30 : -16'sd30;
                iq_in[47:32] = alt ? -16'sd30 : 16'sd30;
                alt = !alt;
            end
            2: begin
                iq_in[31:16] = alt ? 16'sd30 : -16'sd30;
                iq_in[15:0]  = alt ? -16'sd30 : 16'sd30;
                iq_in[63:48] = 16'sd200;
                iq_in[47:32] = 16'sd200;
                alt = !alt;
            end
            3: begin
                for (int c = 0; c < NCH; c++) begin
                    if (stuck[c]) begin
                        iq_in[c*2*IQW +: 2*IQW] = {16'($urandom_range(1, 32767)), 16'($urandom)};
                    end else begin
                        iq_in[c*2*IQW +: 2*IQW] = 32'($urandom);
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        drive_iq();
    endtask

    task automatic idle_wait(input int n);
        enable = 1'b0;
        repeat (n) tick();
    endtask

    task automatic randomize_cfg();
        min_len_th        = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 100));
        max_len_th        = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(500, 4000));
        case ($urandom_range(0, 5))
            0: dc_th = 8'd0;
            1: dc_th = 8'd2;
            2: dc_th = 8'd4;
            3: dc_th = 8'd8;
            4: dc_th = 8'd16;
            default: dc_th = 8'd20;
        endcase
        eq_monitor_enable = 1'($urandom_range(0, 1));
        small_eq_th       = ECW'($urandom_range(0, 10));
    endtask

    task automatic rand_cycle(input int i);
        int a;
        int b;
        if (i % 200 == 0) randomize_cfg();
        if (i % 64 == 0) begin
            for (int c = 0; c < NCH; c++) stuck[c] = ($urandom_range(0, 3) == 0);
        end
        enable          = ($urandom_range(0, 15) != 0);
        power_trigger   = ($urandom_range(0, 31) != 0);
        ch_enable       = NCH'($urandom);
        iq_valid        = ($urandom_range(0, 3) != 0);
        sig_valid       = ($urandom_range(0, 19) == 0);
        signal_len      = 16'($urandom_range(0, 5000));
        equalizer_valid = ($urandom_range(0, 2) != 0);
        stat_clear      = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 3) != 0) begin
            a = int'($urandom_range(0, 10)) - 5;
            b = int'($urandom_range(0, 10)) - 5;
            equalizer = {16'(a), 16'(b)};
        end else if ($urandom_range(0, 7) == 0) begin
            equalizer = {16'h8000, 16'h0001};
        end else begin
            equalizer = $urandom;
        end
    endtask

    int k;
    int w;
    bit got;

    initial begin
        repeat (3) tick();
        rstn = 1'b1;
        #1;
        check("reset_receiver_rst", 32'(receiver_rst), 32'd0);
        check("reset_wd_state",     32'(wd_state),     32'd0);
        check("reset_rst_cause",    32'(rst_cause),    32'd0);
        check("reset_rst_count",    32'(rst_count),    32'd0);
        tick();

        // DC: ch0 I stuck positive
        dc_th = 8'd4;
        ch_enable = 2'b01;
        iq_valid = 1'b1;
        iq_mode = 1;
        enable = 1'b1;
        k = 0;
        got = 0;
        while (k < 60 && !got) begin
            tick();
            k++;
            if (receiver_rst) got = 1;
        end
        check("dc_latency", 32'(k), 32'd34);
        check("dc_cause", 32'(rst_cause), 32'd1);
        check("dc_count", 32'(rst_count), 32'd1);
        enable = 1'b0;
        w = 1;
        while (w < 20) begin
            tick();
            if (!receiver_rst) break;
            w++;
        end
        check("pulse_width", 32'(w), 32'(RPC));
        idle_wait(HOC + 2);
        check("dc_back_idle", 32'(wd_state), 32'd0);

        // LEN: short frame trips, in-window frame does not
        iq_valid = 1'b0;
        iq_mode = 0;
        dc_th = 8'd0;
        ch_enable = 2'b00;
        min_len_th = 16'd14;
        enable = 1'b1;
        tick();
        sig_valid = 1'b1;
        signal_len = 16'd3;
        tick();
        sig_valid = 1'b0;
        check("len_short_rst", 32'(receiver_rst), 32'd1);
        check("len_short_cause", 32'(rst_cause), 32'd2);
        check("len_short_count", 32'(rst_count), 32'd2);
        idle_wait(40);
        max_len_th = 16'd4095;
        enable = 1'b1;
        tick();
        sig_valid = 1'b1;
        signal_len = 16'd1500;
        tick();
        sig_valid = 1'b0;
        tick();
        check("len_ok_no_rst", 32'(receiver_rst), 32'd0);
        check("len_ok_armed", 32'(wd_state), 32'd1);
        check("len_ok_count", 32'(rst_count), 32'd2);
        min_len_th = '0;
        max_len_th = '0;
        idle_wait(3);

        // EQ: run of small outputs, broken once by a large one
        eq_monitor_enable = 1'b1;
        small_eq_th = 6'd6;
        enable = 1'b1;
        tick();
        equalizer_valid = 1'b1;
        equalizer = {16'sd2, -16'sd1};
        repeat (3) tick();
        equalizer = {16'sd100, 16'sd0};
        tick();
        equalizer = {16'sd2, -16'sd1};
        repeat (6) tick();
        equalizer_valid = 1'b0;
        check("eq_not_early", 32'(receiver_rst), 32'd0);
        tick();
        check("eq_rst", 32'(receiver_rst), 32'd1);
        check("eq_cause", 32'(rst_cause), 32'd4);
        check("eq_count", 32'(rst_count), 32'd3);
        eq_monitor_enable = 1'b0;
        small_eq_th = '0;
        idle_wait(40);

        // Simultaneous DC + LEN, then a LEN fault during holdoff is ignored
        dc_th = 8'd4;
        ch_enable = 2'b01;
        iq_valid = 1'b1;
        iq_mode = 1;
        min_len_th = 16'd14;
        enable = 1'b1;
        repeat (33) tick();
        sig_valid = 1'b1;
        signal_len = 16'd0;
        tick();
        sig_valid = 1'b0;
        check("both_rst", 32'(receiver_rst), 32'd1);
        check("both_cause", 32'(rst_cause), 32'd3);
        check("both_count", 32'(rst_count), 32'd4);
        enable = 1'b0;
        repeat (6) tick();
        check("holdoff_state", 32'(wd_state), 32'd3);
        sig_valid = 1'b1;
        signal_len = 16'd3;
        tick();
        sig_valid = 1'b0;
        tick();
        check("holdoff_ignored", 32'(rst_count), 32'd4);
        idle_wait(40);

        // Async reset in the middle of a pulse
        iq_valid = 1'b0;
        iq_mode = 0;
        dc_th = 8'd0;
        enable = 1'b1;
        tick();
        sig_valid = 1'b1;
        signal_len = 16'd3;
        tick();
        sig_valid = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        check("async_receiver_rst", 32'(receiver_rst), 32'd0);
        check("async_wd_state", 32'(wd_state), 32'd0);
        check("async_count", 32'(rst_count), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        min_len_th = '0;
        idle_wait(2);

        // Disabled stuck channel must not trip
        dc_th = 8'd4;
        ch_enable = 2'b01;
        iq_valid = 1'b1;
        iq_mode = 2;
        enable = 1'b1;
        repeat (60) tick();
        check("chdis_count", 32'(rst_count), 32'd0);
        check("chdis_armed", 32'(wd_state), 32'd1);
        idle_wait(2);

        // Saturation of the fault counter, then clear
        iq_valid = 1'b0;
        iq_mode = 0;
        dc_th = 8'd0;
        force dut.rst_count = 16'hFFFF;
        m_count = 65535;
        tick();
        release dut.rst_count;
        min_len_th = 16'd14;
        enable = 1'b1;
        tick();
        sig_valid = 1'b1;
        signal_len = 16'd3;
        tick();
        sig_valid = 1'b0;
        check("sat_count", 32'(rst_count), 32'd65535);
        check("sat_cause", 32'(rst_cause), 32'd2);
        idle_wait(40);
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        check("clear_count", 32'(rst_count), 32'd0);
        check("clear_cause", 32'(rst_cause), 32'd0);

        // Randomized traffic against the model
        iq_mode = 3;
        for (int i = 0; i < 4000; i++) begin
            rand_cycle(i);
            tick();
        end
        enable = 1'b0;
        sig_valid = 1'b0;
        stat_clear = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
